// File: rtl/s_mem_arbiter.sv
// -----------------------------------------------------------------------------
// s_mem_arbiter
//
// Shares the single-port 256x8 S-box RAM between the three sequencing FSMs:
// index 0 = s[i]=i init fill, 1 = KSA shuffle, 2 = PRGA/decrypt.
// Arbitration is round-robin with lock-until-release. Once granted, a
// requester keeps the RAM until it drops req, and only the owner drives the
// RAM address, write data and write enable. Read data from the RAM is
// broadcast to everyone. A per-requester rvalid pulse marks the cycle in
// which that requester's read data is present on rdata.
//
// Ports
//   CLOCK_50   in   system clock, all logic on the rising edge
//   reset_n    in   asynchronous active-low reset
//   abort      in   synchronous flush: drop grant, kill reads in flight
//   req        in   [NREQ]     bus request, held high for the whole ownership
//   en         in   [NREQ]     access strobe, at most one RAM access per cycle
//   wren       in   [NREQ]     write enable, only meaningful with en
//   addr       in   [NREQ*AW]  packed addresses, requester k at [k*AW +: AW]
//   wdata      in   [NREQ*DW]  packed write data, same packing
//   grant      out  [NREQ]     one-hot ownership, registered
//   rvalid     out  [NREQ]     one pulse per completed read
//   rdata      out  [DW]       RAM q, broadcast
//   busy       out  any grant asserted
//   owner      out  [2]        index of the current or most recent owner
//   mem_addr   out  [AW]       RAM address
//   mem_wdata  out  [DW]       RAM write data
//   mem_wren   out  RAM write enable
//   mem_q      in   [DW]       RAM read data
// -----------------------------------------------------------------------------
module s_mem_arbiter #(
    parameter int NREQ   = 3,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic                 abort,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      en,
    input  logic [NREQ-1:0]      wren,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic [1:0]           owner,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    output logic                 mem_wren,
    input  logic [DW-1:0]        mem_q
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [NREQ-1:0]   grant_next;
    logic [1:0]        owner_next;
    logic              owner_req;
    logic              found;
    logic [NREQ-1:0]   rd_issue;
    logic [NREQ-1:0]   rv_pipe [RD_LAT];

    // req bit of the current owner, selected without a variable index so the
    // width of owner never has to match NREQ exactly.
    always_comb begin
        owner_req = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner == 2'(k)) begin
                owner_req = req[k];
            end
        end
    end

    // Next-state logic. owner doubles as the round-robin pointer: the search
    // starts one past the last owner, so after a release the previous owner
    // has the lowest priority. abort wins over everything and sends the FSM
    // back to IDLE without touching owner.
    always_comb begin
        state_next = state;
        grant_next = grant;
        owner_next = owner;
        found      = 1'b0;
        case (state)
            IDLE: begin
                grant_next = '0;
                if (!abort) begin
                    for (int i = 1; i <= NREQ; i++) begin
                        for (int k = 0; k < NREQ; k++) begin
                            if (!found && (k == ((int'(owner) + i) % NREQ)) && req[k]) begin
                                found         = 1'b1;
                                owner_next    = 2'(k);
                                grant_next    = '0;
                                grant_next[k] = 1'b1;
                                state_next    = OWN;
                            end
                        end
                    end
                end
            end
            OWN: begin
                if (abort || !owner_req) begin
                    grant_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    // State, grant and owner registers. On reset the pointer sits on the last
    // requester so that requester 0 is searched first.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= '0;
            owner <= 2'(NREQ - 1);
        end else begin
            state <= state_next;
            grant <= grant_next;
            owner <= owner_next;
        end
    end

    // RAM-side mux. Address and write data follow owner even when nothing is
    // granted (the RAM ignores them then); the write enable additionally needs
    // the grant so a released or non-owning requester can never write.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner == 2'(k)) begin
                mem_addr  = addr[k*AW +: AW];
                mem_wdata = wdata[k*DW +: DW];
                mem_wren  = grant[k] & en[k] & wren[k];
            end
        end
    end

    // A read is an owned access without write. Because grant is one-hot this
    // vector has at most one bit set and already identifies the requester.
    assign rd_issue = grant & en & ~wren;

    // Read tracking shift register, one stage per cycle of RAM latency.
    // Reads keep travelling after the requester releases the bus; only abort
    // or reset wipes them, including a read issued in the abort cycle.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rv_pipe[i] <= '0;
            end
        end else if (abort) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rv_pipe[i] <= '0;
            end
        end else begin
            rv_pipe[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                rv_pipe[i] <= rv_pipe[i-1];
            end
        end
    end

    assign rvalid = rv_pipe[RD_LAT-1];
    assign rdata  = mem_q;
    assign busy   = |grant;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_s_mem_arbiter
//
// Two arbiters share every input: dut_a with RD_LAT=1 and dut_b with RD_LAT=2.
// Each one drives its own behavioural RAM whose read latency matches. The
// directed scenarios carry hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_s_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        abort;
    logic [2:0]  req;
    logic [2:0]  en;
    logic [2:0]  wren;
    logic [23:0] addr;
    logic [23:0] wdata;

    logic [2:0]  grant_a, rvalid_a, grant_b, rvalid_b;
    logic [7:0]  rdata_a, rdata_b;
    logic        busy_a, busy_b;
    logic [1:0]  owner_a, owner_b;
    logic [7:0]  mem_addr_a, mem_wdata_a, mem_addr_b, mem_wdata_b;
    logic        mem_wren_a, mem_wren_b;
    logic [7:0]  q_a, q_b, q_b1;

    logic [7:0]  ram_a [256];
    logic [7:0]  ram_b [256];

    int n_cmp = 0;
    int n_bad = 0;

    s_mem_arbiter #(.NREQ(3), .AW(8), .DW(8), .RD_LAT(1)) dut_a (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .abort    (abort),
        .req      (req),
        .en       (en),
        .wren     (wren),
        .addr     (addr),
        .wdata    (wdata),
        .grant    (grant_a),
        .rvalid   (rvalid_a),
        .rdata    (rdata_a),
        .busy     (busy_a),
        .owner    (owner_a),
        .mem_addr (mem_addr_a),
        .mem_wdata(mem_wdata_a),
        .mem_wren (mem_wren_a),
        .mem_q    (q_a)
    );

    s_mem_arbiter #(.NREQ(3), .AW(8), .DW(8), .RD_LAT(2)) dut_b (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .abort    (abort),
        .req      (req),
        .en       (en),
        .wren     (wren),
        .addr     (addr),
        .wdata    (wdata),
        .grant    (grant_b),
        .rvalid   (rvalid_b),
        .rdata    (rdata_b),
        .busy     (busy_b),
        .owner    (owner_b),
        .mem_addr (mem_addr_b),
        .mem_wdata(mem_wdata_b),
        .mem_wren (mem_wren_b),
        .mem_q    (q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAMs: registered output (1 cycle) and an extra stage (2 cycles).
    always @(posedge clk) begin
        if (mem_wren_a) ram_a[mem_addr_a] <= mem_wdata_a;
        q_a <= ram_a[mem_addr_a];
        if (mem_wren_b) ram_b[mem_addr_b] <= mem_wdata_b;
        q_b1 <= ram_b[mem_addr_b];
        q_b  <= q_b1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int k, input logic [7:0] a, input logic [7:0] d);
        addr[k*8 +: 8]  = a;
        wdata[k*8 +: 8] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; abort = 1'b0; req = '0; en = '0; wren = '0; addr = '0; wdata = '0;
        tick(); tick();
        n_cmp++; if (grant_a !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_grant: got %b expected 000", grant_a); end
        n_cmp++; if (rvalid_a !== 3'b000 || rvalid_b !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_rvalid: got %b/%b expected 000", rvalid_a, rvalid_b); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_a); end
        n_cmp++; if (owner_a !== 2'd2) begin n_bad++; $display("[TB] FAIL reset_owner: got %0d expected 2", owner_a); end
        rst_n = 1'b1;
        req = 3'b001;
        tick();
        n_cmp++; if (grant_a !== 3'b001 || owner_a !== 2'd0) begin n_bad++; $display("[TB] FAIL first_grant: got %b/%0d expected 001/0", grant_a, owner_a); end
        en = 3'b001; wren = 3'b001; set_port(0, 8'h33, 8'h44);
        #1;
        n_cmp++; if (mem_wren_a !== 1'b1) begin n_bad++; $display("[TB] FAIL own_wren: got %b expected 1", mem_wren_a); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (grant_a !== 3'b000 || busy_a !== 1'b0) begin n_bad++; $display("[TB] FAIL async_grant: got %b expected 000", grant_a); end
        n_cmp++; if (mem_wren_a !== 1'b0 || rvalid_a !== 3'b000) begin n_bad++; $display("[TB] FAIL async_wren: got %b/%b expected 0/000", mem_wren_a, rvalid_a); end
        en = '0; wren = '0;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (grant_a !== 3'b001 || owner_a !== 2'd0) begin n_bad++; $display("[TB] FAIL regrant_after_reset: got %b/%0d expected 001/0", grant_a, owner_a); end
        req = '0;
        tick();
        n_cmp++; if (grant_a !== 3'b000) begin n_bad++; $display("[TB] FAIL release_after_reset: got %b expected 000", grant_a); end
    endtask

    task automatic test_init_fill();
        int bad_wr;
        int bad_ram;
        bad_wr = 0; bad_ram = 0;
        req = 3'b001;
        tick();
        for (int i = 0; i < 256; i++) begin
            en = 3'b001; wren = 3'b001; set_port(0, 8'(i), 8'(i));
            #1;
            if (grant_a !== 3'b001 || mem_wren_a !== 1'b1 || mem_addr_a !== 8'(i) || mem_wdata_a !== 8'(i)) begin
                bad_wr++;
                if (bad_wr <= 4) $display("[TB] FAIL fill_write: i=%0d got grant=%b wren=%b addr=%h data=%h expected 001/1/%h/%h",
                                          i, grant_a, mem_wren_a, mem_addr_a, mem_wdata_a, 8'(i), 8'(i));
            end
            tick();
        end
        en = '0; wren = '0; req = '0;
        tick();
        for (int i = 0; i < 256; i++) begin
            if (ram_a[i] !== 8'(i)) begin
                bad_ram++;
                if (bad_ram <= 4) $display("[TB] FAIL fill_ram: entry %0d got %h expected %h", i, ram_a[i], 8'(i));
            end
        end
        n_cmp++; if (bad_wr != 0) n_bad++;
        n_cmp++; if (bad_ram != 0) n_bad++;
        n_cmp++; if (grant_a !== 3'b000 || owner_a !== 2'd0) begin n_bad++; $display("[TB] FAIL fill_release: got %b/%0d expected 000/0", grant_a, owner_a); end
    endtask

    task automatic test_ignore_nongranted();
        req = 3'b001;
        tick();
        en = 3'b110; wren = 3'b010; set_port(1, 8'h07, 8'hEE); set_port(2, 8'h08, 8'h00);
        #1;
        n_cmp++; if (mem_wren_a !== 1'b0) begin n_bad++; $display("[TB] FAIL nongrant_wren: got %b expected 0", mem_wren_a); end
        tick();
        en = '0; wren = '0;
        n_cmp++; if (rvalid_a !== 3'b000) begin n_bad++; $display("[TB] FAIL nongrant_rvalid: got %b expected 000", rvalid_a); end
        tick();
        n_cmp++; if (rvalid_b !== 3'b000 || ram_a[7] !== 8'h07) begin n_bad++; $display("[TB] FAIL nongrant_effect: got rvalid_b=%b ram7=%h expected 000/07", rvalid_b, ram_a[7]); end
        req = '0;
        tick();
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 1, 2, 0};
        int bad_hold;
        bad_hold = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 3'b111;
        tick();
        for (int j = 0; j < 4; j++) begin
            int k;
            logic [2:0] oh;
            k = order[j];
            oh = 3'b001 << k;
            n_cmp++; if (grant_a !== oh || owner_a !== 2'(k)) begin n_bad++; $display("[TB] FAIL rr_grant_%0d: got %b/%0d expected %b/%0d", j, grant_a, owner_a, oh, k); end
            for (int c = 0; c < 4; c++) begin
                en = oh; wren = '0; set_port(k, 8'(c), 8'h00);
                tick();
                if (grant_a !== oh) begin
                    bad_hold++;
                    $display("[TB] FAIL rr_hold: owner %0d access %0d got %b expected %b", k, c, grant_a, oh);
                end
            end
            en = '0;
            req[k] = 1'b0;
            tick();
            n_cmp++; if (grant_a !== 3'b000 || busy_a !== 1'b0) begin n_bad++; $display("[TB] FAIL rr_gap_%0d: got %b expected 000", j, grant_a); end
            req[k] = 1'b1;
            tick();
        end
        n_cmp++; if (bad_hold != 0) n_bad++;
        req = '0;
        tick();
    endtask

    task automatic test_read_latency();
        req = 3'b010;
        tick();
        n_cmp++; if (grant_a !== 3'b010) begin n_bad++; $display("[TB] FAIL rd_grant: got %b expected 010", grant_a); end
        en = 3'b010; wren = 3'b010; set_port(1, 8'h05, 8'hA3);
        #1;
        n_cmp++; if (mem_wren_a !== 1'b1 || mem_addr_a !== 8'h05 || mem_wdata_a !== 8'hA3) begin n_bad++; $display("[TB] FAIL rd_write: got %b/%h/%h expected 1/05/a3", mem_wren_a, mem_addr_a, mem_wdata_a); end
        tick();
        wren = '0;
        #1;
        n_cmp++; if (mem_wren_a !== 1'b0) begin n_bad++; $display("[TB] FAIL rd_wren_low: got %b expected 0", mem_wren_a); end
        tick();
        n_cmp++; if (rvalid_a !== 3'b010 || rdata_a !== 8'hA3) begin n_bad++; $display("[TB] FAIL rd_lat1: got %b/%h expected 010/a3", rvalid_a, rdata_a); end
        n_cmp++; if (rvalid_b !== 3'b000) begin n_bad++; $display("[TB] FAIL rd_lat2_early: got %b expected 000", rvalid_b); end
        set_port(1, 8'd10, 8'h00);
        tick();
        n_cmp++; if (rvalid_a !== 3'b010 || rdata_a !== 8'd10) begin n_bad++; $display("[TB] FAIL rd_b2b_1: got %b/%h expected 010/0a", rvalid_a, rdata_a); end
        n_cmp++; if (rvalid_b !== 3'b010 || rdata_b !== 8'hA3) begin n_bad++; $display("[TB] FAIL rd_lat2: got %b/%h expected 010/a3", rvalid_b, rdata_b); end
        en = '0;
        tick();
        n_cmp++; if (rvalid_a !== 3'b000) begin n_bad++; $display("[TB] FAIL rd_done: got %b expected 000", rvalid_a); end
        n_cmp++; if (rvalid_b !== 3'b010 || rdata_b !== 8'd10) begin n_bad++; $display("[TB] FAIL rd_b2b_2: got %b/%h expected 010/0a", rvalid_b, rdata_b); end
        req = '0;
        tick();
    endtask

    task automatic test_release_in_flight();
        req = 3'b010;
        tick();
        en = 3'b010; wren = '0; set_port(1, 8'h05, 8'h00);
        req = 3'b000;
        tick();
        en = '0;
        n_cmp++; if (grant_b !== 3'b000) begin n_bad++; $display("[TB] FAIL rel_grant: got %b expected 000", grant_b); end
        n_cmp++; if (rvalid_a !== 3'b010 || rvalid_b !== 3'b000) begin n_bad++; $display("[TB] FAIL rel_stage1: got %b/%b expected 010/000", rvalid_a, rvalid_b); end
        tick();
        n_cmp++; if (rvalid_b !== 3'b010 || rdata_b !== 8'hA3 || grant_b !== 3'b000) begin n_bad++; $display("[TB] FAIL rel_rvalid: got %b/%h/%b expected 010/a3/000", rvalid_b, rdata_b, grant_b); end
    endtask

    task automatic test_abort();
        req = 3'b100;
        tick();
        n_cmp++; if (grant_a !== 3'b100 || owner_a !== 2'd2) begin n_bad++; $display("[TB] FAIL ab_grant: got %b/%0d expected 100/2", grant_a, owner_a); end
        en = 3'b100; wren = '0; set_port(2, 8'd10, 8'h00);
        tick();
        set_port(2, 8'd20, 8'h00);
        abort = 1'b1;
        #1;
        n_cmp++; if (rvalid_a !== 3'b100 || rdata_a !== 8'd10) begin n_bad++; $display("[TB] FAIL ab_pre_read: got %b/%h expected 100/0a", rvalid_a, rdata_a); end
        tick();
        en = 3'b100; wren = 3'b100;
        #1;
        n_cmp++; if (grant_a !== 3'b000 || busy_a !== 1'b0) begin n_bad++; $display("[TB] FAIL ab_grant_drop: got %b expected 000", grant_a); end
        n_cmp++; if (rvalid_a !== 3'b000 || rvalid_b !== 3'b000) begin n_bad++; $display("[TB] FAIL ab_kill: got %b/%b expected 000/000", rvalid_a, rvalid_b); end
        n_cmp++; if (mem_wren_a !== 1'b0) begin n_bad++; $display("[TB] FAIL ab_wren: got %b expected 0", mem_wren_a); end
        tick();
        n_cmp++; if (grant_a !== 3'b000 || rvalid_b !== 3'b000) begin n_bad++; $display("[TB] FAIL ab_held: got %b/%b expected 000/000", grant_a, rvalid_b); end
        n_cmp++; if (owner_a !== 2'd2) begin n_bad++; $display("[TB] FAIL ab_owner: got %0d expected 2", owner_a); end
        abort = 1'b0; en = '0; wren = '0;
        tick();
        n_cmp++; if (grant_a !== 3'b100) begin n_bad++; $display("[TB] FAIL ab_regrant: got %b expected 100", grant_a); end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_init_fill();
        test_ignore_nongranted();
        test_round_robin();
        test_read_latency();
        test_release_in_flight();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
